// File: rtl/prbs_checker.sv
// PRBS receive checker: locks a local LFSR predictor to the incoming words, then flags mismatches and counts them.
// Outputs are registered one edge after each valid word; no backpressure, and in_valid=0 freezes all state.
module prbs_checker #(
    parameter int WIDTH    = 4,
    parameter int LOCK_CNT = 4,
    parameter int LOSS_CNT = 3,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             clr_cnt,
    output logic             locked,
    output logic             err,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] word_count
);

    generate
        if (WIDTH != 4 && WIDTH != 8) begin : g_bad_width
            $error("prbs_checker: WIDTH must be 4 or 8");
        end
    endgenerate

    localparam int RUN_W  = $clog2(LOCK_CNT + 1);
    localparam int MISS_W = $clog2(LOSS_CNT + 1);
    // Feedback taps: x^4+x^3 for 4-bit words, x^8+x^6+x^3+x^2 for 8-bit words.
    localparam logic [WIDTH-1:0] TAPS = (WIDTH == 8) ? WIDTH'(8'hA6) : WIDTH'(4'hC);

    typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;

    state_t            state, state_nx;
    logic [WIDTH-1:0]  pred, pred_nx;
    logic [RUN_W-1:0]  run, run_nx, run_inc;
    logic [MISS_W-1:0] miss, miss_nx, miss_inc;
    logic              err_nx;
    logic              err_inc;
    logic              word_inc;

    function automatic logic [WIDTH-1:0] nxt(input logic [WIDTH-1:0] d);
        return {d[WIDTH-2:0], ^(d & TAPS)};
    endfunction

    assign run_inc  = run + RUN_W'(1);
    assign miss_inc = miss + MISS_W'(1);

    always_comb begin
        state_nx = state;
        pred_nx  = pred;
        run_nx   = run;
        miss_nx  = miss;
        err_nx   = 1'b0;
        err_inc  = 1'b0;
        word_inc = 1'b0;
        if (in_valid) begin
            case (state)
                SEARCH: begin
                    if (in_data != '0) begin
                        pred_nx  = nxt(in_data);
                        run_nx   = '0;
                        state_nx = VERIFY;
                    end
                end
                VERIFY: begin
                    if (in_data == pred) begin
                        pred_nx = nxt(pred);
                        run_nx  = run_inc;
                        if (run_inc == RUN_W'(LOCK_CNT)) begin
                            state_nx = LOCKED;
                            miss_nx  = '0;
                        end
                    end else if (in_data != '0) begin
                        pred_nx = nxt(in_data);
                        run_nx  = '0;
                    end else begin
                        state_nx = SEARCH;
                    end
                end
                LOCKED: begin
                    // Predictor free-runs so one corrupted word costs exactly one error.
                    pred_nx  = nxt(pred);
                    word_inc = 1'b1;
                    if (in_data == pred) begin
                        miss_nx = '0;
                    end else begin
                        err_nx  = 1'b1;
                        err_inc = 1'b1;
                        miss_nx = miss_inc;
                        if (miss_inc == MISS_W'(LOSS_CNT)) begin
                            state_nx = SEARCH;
                        end
                    end
                end
                default: state_nx = SEARCH;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= SEARCH;
            pred   <= '0;
            run    <= '0;
            miss   <= '0;
            locked <= 1'b0;
            err    <= 1'b0;
        end else begin
            state  <= state_nx;
            pred   <= pred_nx;
            run    <= run_nx;
            miss   <= miss_nx;
            locked <= (state_nx == LOCKED);
            err    <= err_nx;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_count  <= '0;
            word_count <= '0;
        end else if (clr_cnt) begin
            err_count  <= '0;
            word_count <= '0;
        end else begin
            if (err_inc && (err_count != '1)) begin
                err_count <= err_count + CNT_W'(1);
            end
            if (word_inc && (word_count != '1)) begin
                word_count <= word_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: doc/prbs_checker.md
Name: prbs_checker

Overview:
- Receive-side partner of the team's LFSR pattern generator.
- Accepts one WIDTH-bit word per valid cycle and synchronises a local predictor LFSR to the incoming sequence.
- Once locked, compares each word against the prediction, flags mismatches and keeps error and word counters.
- Sits at the sink end of a link or BIST path; the generator drives the source end.

Parameters:
- WIDTH, 4, word width. Supported values are 4 and 8 only; any other value is an elaboration-time error.
- LOCK_CNT, 4, consecutive correct predictions required to declare lock (>=1).
- LOSS_CNT, 3, consecutive mismatches while locked that drop lock (>=1).
- CNT_W, 16, width of err_count and word_count.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  in_data is valid this cycle.
- in_data  in  WIDTH  received pattern word.
- clr_cnt  in  1  synchronous clear of err_count and word_count.
- locked  out  1  high while the FSM is in LOCKED.
- err  out  1  one-cycle pulse, registered, for each mismatching word while locked.
- err_count  out  CNT_W  saturating count of mismatching words.
- word_count  out  CNT_W  saturating count of words checked while locked.

Behaviour:
- Next-state function nxt(d), identical to the generator:
  - WIDTH=4: {d[2:0], d[3]^d[2]}.
  - WIDTH=8: {d[6:0], d[7]^d[5]^d[2]^d[1]}.
- Reset (rst=0, asynchronous): state=SEARCH, pred=0, run=0, miss=0, locked=0, err=0, both counters=0.
- When in_valid=0: no state, predictor or counter change; err=0 on the next cycle.
- FSM states:
  - SEARCH, on a valid word:
    - in_data==0: stay in SEARCH (an all-zero word is a lockup value).
    - Otherwise: pred<=nxt(in_data), run<=0, go to VERIFY.
  - VERIFY, on a valid word:
    - in_data==pred: pred<=nxt(pred), run<=run+1. If run+1==LOCK_CNT, go to LOCKED with miss<=0.
    - Mismatch with in_data!=0: reseed pred<=nxt(in_data), run<=0, stay in VERIFY.
    - Mismatch with in_data==0: go to SEARCH.
  - LOCKED, on a valid word:
    - Always pred<=nxt(pred). The predictor free-runs, so a single bad word causes exactly one error.
    - word_count increments on every valid word.
    - Match: miss<=0.
    - Mismatch: err=1 on the next cycle, err_count increments, miss<=miss+1.
    - If miss+1==LOSS_CNT, go to SEARCH and deassert locked at that edge.
- locked is registered. It rises at the edge that accepts the LOCK_CNT-th consecutive match, i.e. one word after the seed plus LOCK_CNT words.
- Counters saturate at all-ones and do not wrap.
- clr_cnt=1 zeroes both counters at the next edge. It takes priority over a simultaneous increment. It does not affect the FSM state or locked.
- The err pulse is independent of counter saturation and of clr_cnt.
- The FSM never enters LOCKED with pred==0: the zero check in SEARCH and VERIFY guarantees a nonzero predictor.

Test Plan:
- Lock acquisition, WIDTH=4, LOCK_CNT=4: after reset, send 0001,0010,0100,1001,0011 -> locked rises after 0011; err never high; word_count=0.
- Single error: locked, expected 0110, send 0111, then 1101,1010 -> err=1 for exactly one cycle; err_count=1; locked stays 1; no further errors; word_count=3.
- Loss of lock, LOSS_CNT=3: locked, send three corrupted words (0000,1111,0000) in place of 0101,1011,0111 -> locked falls after the third; err_count=3; state SEARCH. Resend 0111,1111,1110,1100,1000 -> relock.
- Zero and gap handling: in SEARCH, send 0000 x5 -> no transition. Insert in_valid=0 gaps between locked words -> no errors, predictor holds across gaps.
- WIDTH=8 with seed 8'h01: send a generator-produced sequence of 20 words -> lock after 5 words, zero errors, word_count=15.
- Counters and reset: CNT_W=2, inject 5 errors while staying locked -> err_count=3 (saturated). Assert clr_cnt in the same cycle as an error -> err_count=0 and err still pulses. Assert rst low mid-stream -> all outputs 0 immediately, without waiting for a clock edge.
